// File: rtl/motor_cmd_scheduler.sv
// rtl/motor_cmd_scheduler.sv - motor command arbiter and JSON frame sequencer
module motor_cmd_scheduler #(
  parameter int N_REQ    = 3,
  parameter int PERIOD   = 500,
  parameter int TICK_DIV = 50000,
  parameter int LEASE    = 100,
  localparam int TW = $clog2(PERIOD),
  localparam int GW = (N_REQ > 1) ? $clog2(N_REQ) : 1
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [N_REQ-1:0]   req_valid,
  input  logic [N_REQ*5-1:0] req_cmd,
  input  logic               snd_valid,
  input  logic               snd_ready,
  output logic [TW-1:0]      timer_value,
  output logic [4:0]         motor_cmd,
  output logic [GW-1:0]      grant_id,
  output logic               grant_valid,
  output logic               frame_busy,
  output logic               cmd_err
);

  localparam int PW = $clog2(TICK_DIV);
  localparam int LW = $clog2(LEASE + 1);

  typedef enum logic [1:0] {COUNT, FIRE, BUSY} state_t;

  state_t          state, state_n;
  logic [PW-1:0]   presc;
  logic            tick;
  logic [TW-1:0]   cnt, cnt_n;
  logic            seen, seen_n, pend, pend_n, pend_now;
  logic [1:0]      wd, wd_n;
  logic            frame_end, commit;
  logic [4:0]      cmd_q [N_REQ];
  logic [LW-1:0]   lease_q [N_REQ];
  logic [N_REQ-1:0] load, bad;
  logic [4:0]      win_cmd;
  logic [GW-1:0]   win_id;
  logic            win_valid;
  logic            handshake_unused;

  // Frame boundaries follow snd_valid alone; the handshake is kept for observability.
  assign handshake_unused = snd_valid & snd_ready;

  assign tick = (presc == PW'(TICK_DIV - 1));

  always_ff @(posedge clk or posedge rst) begin
    if (rst)       presc <= '0;
    else if (tick) presc <= '0;
    else           presc <= presc + PW'(1);
  end

  always_comb begin
    load = '0;
    bad  = '0;
    for (int i = 0; i < N_REQ; i++) begin
      load[i] = req_valid[i] &  $onehot(req_cmd[5*i +: 5]);
      bad[i]  = req_valid[i] & ~$onehot(req_cmd[5*i +: 5]);
    end
  end

  // A fresh load takes precedence over the tick decrement.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cmd_err <= 1'b0;
      for (int i = 0; i < N_REQ; i++) begin
        cmd_q[i]   <= '0;
        lease_q[i] <= '0;
      end
    end else begin
      cmd_err <= |bad;
      for (int i = 0; i < N_REQ; i++) begin
        if (load[i]) begin
          cmd_q[i]   <= req_cmd[5*i +: 5];
          lease_q[i] <= LW'(LEASE);
        end else if (tick && lease_q[i] != '0) begin
          lease_q[i] <= lease_q[i] - LW'(1);
        end
      end
    end
  end

  // Scan from the top so the lowest active index is the last writer.
  always_comb begin
    win_cmd   = 5'b00001;
    win_id    = '0;
    win_valid = 1'b0;
    for (int i = N_REQ - 1; i >= 0; i--) begin
      if (lease_q[i] != '0) begin
        win_cmd   = cmd_q[i];
        win_id    = GW'(i);
        win_valid = 1'b1;
      end
    end
  end

  assign pend_now  = pend | (tick & (cnt == TW'(1)));
  assign frame_end = (state == BUSY) && !snd_valid && (seen || wd == 2'd3);

  always_comb begin
    state_n = state;
    cnt_n   = cnt;
    seen_n  = seen;
    pend_n  = pend;
    wd_n    = wd;
    commit  = 1'b0;
    case (state)
      COUNT: begin
        if (tick) begin
          if (cnt == TW'(1)) begin
            commit  = 1'b1;
            state_n = FIRE;
          end else begin
            cnt_n = cnt - TW'(1);
          end
        end
      end
      FIRE: begin
        cnt_n   = TW'(PERIOD - 1);
        wd_n    = 2'd0;
        seen_n  = 1'b0;
        pend_n  = 1'b0;
        state_n = BUSY;
      end
      BUSY: begin
        if (tick && cnt != TW'(1)) cnt_n = cnt - TW'(1);
        if (wd != 2'd3) wd_n = wd + 2'd1;
        if (frame_end) begin
          seen_n = 1'b0;
          pend_n = 1'b0;
          if (pend_now) begin
            commit  = 1'b1;
            state_n = FIRE;
          end else begin
            state_n = COUNT;
          end
        end else begin
          if (snd_valid) seen_n = 1'b1;
          pend_n = pend_now;
        end
      end
      default: state_n = COUNT;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state       <= COUNT;
      cnt         <= TW'(PERIOD - 1);
      seen        <= 1'b0;
      pend        <= 1'b0;
      wd          <= 2'd0;
      motor_cmd   <= 5'b00001;
      grant_id    <= '0;
      grant_valid <= 1'b0;
    end else begin
      state <= state_n;
      cnt   <= cnt_n;
      seen  <= seen_n;
      pend  <= pend_n;
      wd    <= wd_n;
      if (commit) begin
        motor_cmd   <= win_cmd;
        grant_id    <= win_id;
        grant_valid <= win_valid;
      end
    end
  end

  assign timer_value = (state == FIRE) ? '0 : cnt;
  assign frame_busy  = (state != COUNT);

endmodule

// File: tb/tb_motor_cmd_scheduler.sv
// tb/tb_motor_cmd_scheduler.sv - randomized and directed bench against a behavioural model
module tb_motor_cmd_scheduler;
  localparam int N = 3, P = 8, TD = 4, L = 3;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [2:0]  req_valid = '0;
  logic [14:0] req_cmd = '0;
  logic        snd_valid = 1'b0;
  logic        snd_ready = 1'b1;
  logic [2:0]  timer_value;
  logic [4:0]  motor_cmd;
  logic [1:0]  grant_id;
  logic        grant_valid, frame_busy, cmd_err;

  int checks = 0, errors = 0;
  int mode = 0;  // sender behaviour: 0 normal, 1 overrun, 2 silent

  motor_cmd_scheduler #(.N_REQ(N), .PERIOD(P), .TICK_DIV(TD), .LEASE(L)) dut (
    .clk(clk), .rst(rst), .req_valid(req_valid), .req_cmd(req_cmd),
    .snd_valid(snd_valid), .snd_ready(snd_ready), .timer_value(timer_value),
    .motor_cmd(motor_cmd), .grant_id(grant_id), .grant_valid(grant_valid),
    .frame_busy(frame_busy), .cmd_err(cmd_err)
  );

  always #5 clk = ~clk;

  task automatic check(input string nm, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d, expected %0d", nm, act, exp);
    end
  endtask

  // Behavioural model: frame countdown, lease table, sender-snooped frame end
  int m_pre, m_rem, m_age, m_lease[N];
  bit m_fire, m_busy, m_seen, m_pend;
  logic [4:0] m_tab[N];
  int e_cmd, e_gid, e_gv, e_err;

  task automatic m_init();
    m_pre = 0; m_rem = P - 1; m_age = 0;
    m_fire = 0; m_busy = 0; m_seen = 0; m_pend = 0;
    for (int i = 0; i < N; i++) begin m_lease[i] = 0; m_tab[i] = 0; end
    e_cmd = 1; e_gid = 0; e_gv = 0; e_err = 0;
  endtask

  task automatic m_step();
    bit tk, c, pn, fe, ld;
    int w;
    tk = (m_pre == TD - 1);
    m_pre = (m_pre + 1) % TD;
    w = -1;
    for (int i = 0; i < N; i++) if (m_lease[i] > 0 && w < 0) w = i;
    c = 0;
    if (m_fire) begin
      m_fire = 0; m_busy = 1; m_rem = P - 1; m_age = 1; m_seen = 0; m_pend = 0;
    end else if (m_busy) begin
      pn = m_pend || (tk && m_rem == 1);
      fe = !snd_valid && (m_seen || m_age == 4);
      if (tk && m_rem > 1) m_rem--;
      if (fe) begin
        m_busy = 0; m_seen = 0; m_pend = 0;
        if (pn) begin c = 1; m_fire = 1; end
      end else begin
        if (snd_valid) m_seen = 1;
        m_pend = pn;
        m_age++;
      end
    end else if (tk) begin
      if (m_rem == 1) begin c = 1; m_fire = 1; end
      else m_rem--;
    end
    if (c) begin
      e_cmd = (w < 0) ? 1 : int'(m_tab[w]);
      e_gid = (w < 0) ? 0 : w;
      e_gv  = (w >= 0);
    end
    e_err = 0;
    for (int i = 0; i < N; i++) begin
      ld = req_valid[i] && ($countones(req_cmd[5*i +: 5]) == 1);
      if (ld) begin m_tab[i] = req_cmd[5*i +: 5]; m_lease[i] = L; end
      else if (tk && m_lease[i] > 0) m_lease[i]--;
      if (req_valid[i] && !ld) e_err = 1;
    end
  endtask

  initial begin
    m_init();
    forever begin
      @(posedge clk or posedge rst);
      if (rst) m_init();
      else m_step();
    end
  end

  always @(negedge clk) begin
    if (!rst) begin
      check("timer_value", int'(timer_value), m_fire ? 0 : m_rem);
      check("frame_busy", int'(frame_busy), int'(m_fire || m_busy));
      check("motor_cmd", int'(motor_cmd), e_cmd);
      check("grant_id", int'(grant_id), e_gid);
      check("grant_valid", int'(grant_valid), e_gv);
      check("cmd_err", int'(cmd_err), e_err);
    end
  end

  // Sender stand-in: starts a burst a few cycles after each timer_value==0
  initial begin
    int dly, len;
    forever begin
      @(negedge clk);
      if (!rst && timer_value == 0 && mode != 2) begin
        dly = $urandom_range(1, 3);
        len = (mode == 1) ? 40 : $urandom_range(1, 12);
        repeat (dly) @(posedge clk);
        #2 snd_valid = 1'b1;
        repeat (len) @(posedge clk);
        #2 snd_valid = 1'b0;
      end
    end
  end

  task automatic wait_fire();
    int n = 0;
    do begin @(negedge clk); n++; end while (timer_value != 0 && n < 200);
    check("wait_fire_timeout", int'(timer_value == 0), 1);
  endtask

  task automatic wait_timer(input int v);
    int n = 0;
    do begin @(negedge clk); n++; end while (int'(timer_value) != v && n < 200);
    check("wait_timer_timeout", int'(timer_value), v);
  endtask

  task automatic do_req(input logic [2:0] v, input logic [14:0] c);
    #1 req_valid = v; req_cmd = c;
    @(posedge clk);
    #2 req_valid = '0; req_cmd = '0;
  endtask

  initial begin
    int n;
    logic [4:0] held;
    repeat (3) @(negedge clk);
    check("rst_timer", int'(timer_value), 7);
    check("rst_motor", int'(motor_cmd), 1);
    check("rst_busy", int'(frame_busy), 0);
    check("rst_gv", int'(grant_valid), 0);
    #1 rst = 1'b0;

    // no requests: first FIRE 28 cycles after release
    n = 0;
    while (timer_value != 0 && n < 100) begin @(posedge clk); #1 n++; end
    check("first_fire_latency", n, 28);
    check("idle_motor", int'(motor_cmd), 1);
    check("idle_gv", int'(grant_valid), 0);

    // priority
    wait_timer(3);
    do_req(3'b110, {5'b10000, 5'b00010, 5'b00000});
    wait_fire();
    check("prio_cmd", int'(motor_cmd), 5'b00010);
    check("prio_gid", int'(grant_id), 1);
    wait_timer(2);
    do_req(3'b001, {10'b0, 5'b01000});
    wait_fire();
    check("prio0_cmd", int'(motor_cmd), 5'b01000);
    check("prio0_gid", int'(grant_id), 0);

    // lease expiry boundary: loaded 4 ticks before commit expires, 3 ticks survives
    wait_timer(4);
    do_req(3'b100, {5'b00100, 10'b0});
    wait_fire();
    check("expire_cmd", int'(motor_cmd), 1);
    check("expire_gv", int'(grant_valid), 0);
    wait_timer(3);
    do_req(3'b100, {5'b00100, 10'b0});
    wait_fire();
    check("live_cmd", int'(motor_cmd), 5'b00100);
    check("live_gid", int'(grant_id), 2);

    // bad command
    wait_timer(5);
    do_req(3'b001, {10'b0, 5'b00011});
    @(negedge clk);
    check("bad_err_hi", int'(cmd_err), 1);
    @(negedge clk);
    check("bad_err_lo", int'(cmd_err), 0);
    wait_fire();
    check("bad_no_load", int'(grant_valid), 0);

    // frame overrun
    mode = 1;
    wait_fire();
    held = motor_cmd;
    n = 0;
    while (!snd_valid && n < 10) begin @(negedge clk); n++; end
    check("ovr_start", int'(snd_valid), 1);
    while (snd_valid && n < 100) begin
      check("ovr_timer_nonzero", int'(timer_value != 0), 1);
      check("ovr_cmd_stable", int'(motor_cmd), int'(held));
      @(negedge clk); n++;
    end
    mode = 0;
    check("ovr_end_timer", int'(timer_value), 1);
    check("ovr_end_busy", int'(frame_busy), 1);
    @(negedge clk);
    check("ovr_fire_next", int'(timer_value), 0);

    // mid-frame reset
    mode = 2;
    wait_fire();
    @(negedge clk);
    @(negedge clk);
    #1 rst = 1'b1;
    #1;
    check("mrst_timer", int'(timer_value), 7);
    check("mrst_motor", int'(motor_cmd), 1);
    check("mrst_gid", int'(grant_id), 0);
    check("mrst_gv", int'(grant_valid), 0);
    check("mrst_busy", int'(frame_busy), 0);
    check("mrst_err", int'(cmd_err), 0);
    @(negedge clk);
    #1 rst = 1'b0;

    // watchdog: FIRE plus four silent BUSY cycles
    wait_fire();
    n = 0;
    while (frame_busy && n < 20) begin @(negedge clk); n++; end
    check("watchdog_busy_cycles", n, 5);
    mode = 0;

    // randomized traffic
    for (int k = 0; k < 2000; k++) begin
      @(negedge clk);
      #1;
      if ($urandom_range(0, 4) == 0) begin
        req_valid = 3'($urandom_range(1, 7));
        for (int i = 0; i < N; i++)
          req_cmd[5*i +: 5] = ($urandom_range(0, 3) != 0) ? 5'(1 << $urandom_range(0, 4))
                                                           : 5'($urandom_range(0, 31));
      end else begin
        req_valid = '0;
        req_cmd = '0;
      end
      if ($urandom_range(0, 150) == 0) mode = $urandom_range(0, 2);
    end
    req_valid = '0;
    repeat (60) @(negedge clk);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout: got running, expected finished");
    $fatal(1, "timeout");
  end
endmodule
